// File: rtl/sdram_read.sv
// sdram_read: SDRAM read engine issuing fixed 4-word READ bursts, crossing rows
// and yielding to the arbiter at burst boundaries, closing each row with PRE-all.
module sdram_read #(
    parameter int CAS_LAT = 3,
    parameter int T_RCD   = 2
) (
    input  logic        sclk,
    input  logic        srst_n,
    input  logic        rd_en,
    output logic        flag_rd_ask,
    output logic        flag_rd_end,
    input  logic        rd_trig,
    input  logic [7:0]  rd_len,
    input  logic [20:0] rd_addr,
    input  logic [15:0] sdram_dq,
    output logic [15:0] rd_data,
    output logic        rd_data_vld,
    output logic [3:0]  sdram_cmd,
    output logic [11:0] sdram_addr,
    output logic [1:0]  sdram_bank,
    output logic        busy
);
    localparam int SRW = CAS_LAT + 4;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_PRE = 4'b0010;

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        ASK   = 6'b000010,
        ACT   = 6'b000100,
        RD    = 6'b001000,
        DRAIN = 6'b010000,
        PRE   = 6'b100000
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d, rem_q, rem_d;
    logic [11:0]    row_q, row_d, addr_q, addr_d;
    logic [8:0]     col_q, col_d;
    logic           row_end_q, row_end_d;
    logic [3:0]     cmd_q, cmd_d;
    logic [SRW-1:0] sr_q;
    logic           vld_q;
    logic [15:0]    data_q;
    logic [9:0]     col_sum;

    assign col_sum = {1'b0, col_q} + 10'd4;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        row_d     = row_q;
        col_d     = col_q;
        row_end_d = row_end_q;
        cmd_d     = CMD_NOP;
        addr_d    = 12'h000;
        case (state_q)
            IDLE: if (rd_trig && rd_len != 8'd0) begin
                state_d = ASK;
                row_d   = rd_addr[20:9];
                col_d   = rd_addr[8:0] & 9'h1FC;
                rem_d   = rd_len;
            end
            ASK: if (rd_en) begin
                state_d = ACT;
                cnt_d   = 8'd0;
            end
            ACT: begin
                cmd_d     = (cnt_q == 8'd0) ? CMD_ACT : CMD_NOP;
                addr_d    = (cnt_q == 8'd0) ? row_q : 12'h000;
                row_end_d = (cnt_q == 8'd0) ? 1'b0 : row_end_q;
                state_d   = (cnt_q == 8'(T_RCD - 1)) ? RD : ACT;
                cnt_d     = (cnt_q == 8'(T_RCD - 1)) ? 8'd0 : cnt_q + 8'd1;
            end
            RD: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd0) begin
                    cmd_d  = CMD_RD;
                    addr_d = {3'b000, col_q};
                    col_d  = col_sum[8:0];
                    rem_d  = rem_q - 8'd1;
                    if (col_sum[9]) begin
                        row_end_d = 1'b1;
                        row_d     = row_q + 12'd1;
                    end
                end
                // Continuation is decided in the last cycle of the slot so a grant drop never truncates a burst
                if (cnt_q == 8'd3) begin
                    if (rem_q != 8'd0 && !row_end_q && rd_en) cnt_d = 8'd0;
                    else state_d = DRAIN;
                end
            end
            DRAIN: if (sr_q[SRW-1]) begin
                state_d = PRE;
                cnt_d   = 8'd0;
            end
            PRE: begin
                cmd_d  = (cnt_q == 8'd0) ? CMD_PRE : CMD_NOP;
                addr_d = (cnt_q == 8'd0) ? 12'h400 : 12'h000;
                cnt_d  = cnt_q + 8'd1;
                if (cnt_q == 8'd1 && rem_q != 8'd0 && rd_en) begin
                    state_d = ACT;
                    cnt_d   = 8'd0;
                end
                if (cnt_q == 8'd2) state_d = (rem_q == 8'd0) ? IDLE : ASK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!srst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            rem_q     <= 8'd0;
            row_q     <= 12'h000;
            col_q     <= 9'h000;
            row_end_q <= 1'b0;
            cmd_q     <= CMD_NOP;
            addr_q    <= 12'h000;
            sr_q      <= '0;
            vld_q     <= 1'b0;
            data_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            row_q     <= row_d;
            col_q     <= col_d;
            row_end_q <= row_end_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            sr_q      <= {sr_q[SRW-2:0], cmd_d == CMD_RD};
            vld_q     <= |sr_q[SRW-1:CAS_LAT];
            data_q    <= sdram_dq;
        end
    end

    assign flag_rd_ask = (state_q == ASK);
    assign flag_rd_end = (state_q == PRE) && (cnt_q == 8'd2);
    assign busy        = (state_q != IDLE);
    assign sdram_cmd   = cmd_q;
    assign sdram_addr  = addr_q;
    assign sdram_bank  = 2'b00;
    assign rd_data     = data_q;
    assign rd_data_vld = vld_q;
endmodule

// File: tb/tb_sdram_read.sv
// tb_sdram_read: directed bench for sdram_read with a behavioural SDRAM data model;
// u1 runs CAS_LAT=3, u2 runs CAS_LAT=2, both T_RCD=2 and sharing all stimulus.
module tb_sdram_read;
    logic        sclk = 1'b0, srst_n = 1'b0, rd_en = 1'b0, rd_trig = 1'b0;
    logic [7:0]  rd_len = 8'd0;
    logic [20:0] rd_addr = 21'd0;
    logic [15:0] dq1 = 16'h0, dq2 = 16'h0, data1, data2;
    logic        ask1, end1, vld1, busy1, ask2, end2, vld2, busy2;
    logic [3:0]  cmd1, cmd2;
    logic [11:0] addr1, addr2, row1 = 12'h0, row2 = 12'h0;
    logic [1:0]  bank1, bank2;
    logic [15:0] ring1 [16];
    logic [15:0] ring2 [16];
    int tests_run = 0, tests_failed = 0, cyc = 0, overlap = 0;
    int a_cyc[$], r_cyc[$], p_cyc[$], e_cyc[$], v_cyc[$], r2_cyc[$], v2_cyc[$];
    logic [11:0] a_row[$], r_col[$];
    logic [15:0] v_dat[$], v2_dat[$];

    sdram_read #(.CAS_LAT(3), .T_RCD(2)) u1 (
        .sclk(sclk), .srst_n(srst_n), .rd_en(rd_en), .flag_rd_ask(ask1), .flag_rd_end(end1),
        .rd_trig(rd_trig), .rd_len(rd_len), .rd_addr(rd_addr), .sdram_dq(dq1), .rd_data(data1),
        .rd_data_vld(vld1), .sdram_cmd(cmd1), .sdram_addr(addr1), .sdram_bank(bank1), .busy(busy1));
    sdram_read #(.CAS_LAT(2), .T_RCD(2)) u2 (
        .sclk(sclk), .srst_n(srst_n), .rd_en(rd_en), .flag_rd_ask(ask2), .flag_rd_end(end2),
        .rd_trig(rd_trig), .rd_len(rd_len), .rd_addr(rd_addr), .sdram_dq(dq2), .rd_data(data2),
        .rd_data_vld(vld2), .sdram_cmd(cmd2), .sdram_addr(addr2), .sdram_bank(bank2), .busy(busy2));

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    // SDRAM model: word for (row,col) is {row[6:0], col}, returned CAS_LAT cycles after READ
    always @(negedge sclk) begin
        if (cmd1 == 4'b0011) begin a_cyc.push_back(cyc); a_row.push_back(addr1); row1 = addr1; end
        if (cmd1 == 4'b0101) begin
            r_cyc.push_back(cyc); r_col.push_back(addr1);
            for (int i = 0; i < 4; i++) ring1[(cyc + 3 + i) % 16] = {row1[6:0], addr1[8:0] + 9'(i)};
        end
        if (cmd1 == 4'b0010) p_cyc.push_back(cyc);
        if (end1) e_cyc.push_back(cyc);
        if ((ask1 && end1) || (ask2 && end2)) overlap++;
        if (vld1) begin v_cyc.push_back(cyc); v_dat.push_back(data1); end
        dq1 = ring1[cyc % 16];
        if (cmd2 == 4'b0011) row2 = addr2;
        if (cmd2 == 4'b0101) begin
            r2_cyc.push_back(cyc);
            for (int i = 0; i < 4; i++) ring2[(cyc + 2 + i) % 16] = {row2[6:0], addr2[8:0] + 9'(i)};
        end
        if (vld2) begin v2_cyc.push_back(cyc); v2_dat.push_back(data2); end
        dq2 = ring2[cyc % 16];
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic clear_logs;
        a_cyc.delete(); a_row.delete(); r_cyc.delete(); r_col.delete(); p_cyc.delete();
        e_cyc.delete(); v_cyc.delete(); v_dat.delete(); r2_cyc.delete(); v2_cyc.delete(); v2_dat.delete();
    endtask

    task automatic trigger(input logic [20:0] a, input logic [7:0] l, output int t);
        rd_addr = a; rd_len = l; rd_trig = 1'b1; t = cyc;
        @(negedge sclk);
        rd_trig = 1'b0;
    endtask

    task automatic wait_idle(input int lim, input string nm);
        int n = 0;
        while ((busy1 || busy2) && n < lim) begin @(negedge sclk); n++; end
        tests_run++;
        if (busy1 || busy2) begin
            tests_failed++;
            $display("FAIL %s_timeout busy1=%0b busy2=%0b required 0", nm, busy1, busy2);
        end
        tick(2);
    endtask

    task automatic test_reset;
        srst_n = 1'b0;
        tick(3);
        tests_run++;
        if (cmd1 !== 4'b0111) begin tests_failed++; $display("FAIL reset_cmd got %b want 0111", cmd1); end
        tests_run++;
        if ({addr1, bank1, data1} !== 30'h0) begin tests_failed++; $display("FAIL reset_addr_data got %h/%h/%h want 0", addr1, bank1, data1); end
        tests_run++;
        if ({ask1, end1, vld1, busy1} !== 4'b0) begin tests_failed++; $display("FAIL reset_flags got %b want 0000", {ask1, end1, vld1, busy1}); end
        srst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single;
        int t, c;
        clear_logs();
        rd_en = 1'b1;
        trigger(21'h00010, 8'd1, t);
        tests_run++;
        if (ask1 !== 1'b1) begin tests_failed++; $display("FAIL single_ask got %b want 1", ask1); end
        wait_idle(60, "single");
        c = (r_cyc.size() > 0) ? r_cyc[0] : -100;
        tests_run++;
        if (a_cyc.size() !== 1 || a_cyc[0] !== t + 3 || a_row[0] !== 12'h000) begin
            tests_failed++; $display("FAIL single_act n=%0d cyc=%0d want n=1 cyc=%0d", a_cyc.size(), a_cyc[0], t + 3); end
        tests_run++;
        if (r_cyc.size() !== 1 || c !== t + 5 || r_col[0] !== 12'h010) begin
            tests_failed++; $display("FAIL single_read n=%0d cyc=%0d col=%h want n=1 cyc=%0d col=010", r_cyc.size(), c, r_col[0], t + 5); end
        tests_run++;
        if (v_cyc.size() !== 4 || v_cyc[0] !== c + 4 || v_cyc[3] !== c + 7) begin
            tests_failed++; $display("FAIL single_vld_timing n=%0d first=%0d want n=4 first=%0d", v_cyc.size(), v_cyc[0], c + 4); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (v_dat[i] !== 16'h0010 + 16'(i)) begin tests_failed++; $display("FAIL single_data%0d got %h want %h", i, v_dat[i], 16'h0010 + 16'(i)); end
        end
        tests_run++;
        if (p_cyc.size() !== 1 || p_cyc[0] !== c + 8) begin
            tests_failed++; $display("FAIL single_pre n=%0d cyc=%0d want cyc=%0d", p_cyc.size(), p_cyc[0], c + 8); end
        tests_run++;
        if (e_cyc.size() !== 1 || e_cyc[0] !== c + 9) begin
            tests_failed++; $display("FAIL single_end n=%0d cyc=%0d want cyc=%0d", e_cyc.size(), e_cyc[0], c + 9); end
    endtask

    task automatic test_row_cross;
        int t;
        logic [15:0] exp [16];
        clear_logs();
        trigger(21'h001F8, 8'd4, t);
        wait_idle(100, "row_cross");
        tests_run++;
        if (r_cyc.size() !== 4 || r_col[0] !== 12'h1F8 || r_col[1] !== 12'h1FC || r_col[2] !== 12'h000 || r_col[3] !== 12'h004) begin
            tests_failed++; $display("FAIL row_cross_cols n=%0d got %h %h %h %h want 1f8 1fc 000 004", r_cyc.size(), r_col[0], r_col[1], r_col[2], r_col[3]); end
        tests_run++;
        if (a_cyc.size() !== 2 || a_row[0] !== 12'h000 || a_row[1] !== 12'h001) begin
            tests_failed++; $display("FAIL row_cross_act n=%0d rows %h %h want 000 001", a_cyc.size(), a_row[0], a_row[1]); end
        tests_run++;
        if (p_cyc.size() !== 2 || e_cyc.size() !== 1 || v_cyc.size() !== 16) begin
            tests_failed++; $display("FAIL row_cross_counts pre=%0d end=%0d vld=%0d want 2 1 16", p_cyc.size(), e_cyc.size(), v_cyc.size()); end
        tests_run++;
        if (v_cyc[7] !== v_cyc[0] + 7) begin tests_failed++; $display("FAIL row_cross_b2b got %0d want %0d", v_cyc[7], v_cyc[0] + 7); end
        for (int i = 0; i < 8; i++) begin exp[i] = 16'h01F8 + 16'(i); exp[i + 8] = 16'h0200 + 16'(i); end
        for (int i = 0; i < 16; i += 5) begin
            tests_run++;
            if (v_dat[i] !== exp[i]) begin tests_failed++; $display("FAIL row_cross_data%0d got %h want %h", i, v_dat[i], exp[i]); end
        end
    endtask

    task automatic test_yield;
        int t, n = 0, k = 0;
        clear_logs();
        trigger(21'h00400, 8'd8, t);
        while (n < 2 && k < 40) begin @(negedge sclk); k++; if (cmd1 == 4'b0101) n++; end
        rd_en = 1'b0;
        k = 0;
        while (!end1 && k < 40) begin @(negedge sclk); k++; end
        tick(2);
        tests_run++;
        if (ask1 !== 1'b1 || end1 !== 1'b0 || r_cyc.size() !== 2) begin
            tests_failed++; $display("FAIL yield_ask ask=%b end=%b reads=%0d want 1 0 2", ask1, end1, r_cyc.size()); end
        rd_en = 1'b1;
        wait_idle(150, "yield");
        tests_run++;
        if (r_cyc.size() !== 8 || r_col[2] !== 12'h008 || r_col[7] !== 12'h01C) begin
            tests_failed++; $display("FAIL yield_reads n=%0d col2=%h col7=%h want 8 008 01c", r_cyc.size(), r_col[2], r_col[7]); end
        tests_run++;
        if (a_cyc.size() !== 2 || a_row[1] !== 12'h002 || e_cyc.size() !== 2) begin
            tests_failed++; $display("FAIL yield_act acts=%0d row=%h ends=%0d want 2 002 2", a_cyc.size(), a_row[1], e_cyc.size()); end
        tests_run++;
        if (v_cyc.size() !== 32 || v_dat[8] !== 16'h0408 || v_dat[31] !== 16'h041F) begin
            tests_failed++; $display("FAIL yield_data n=%0d d8=%h d31=%h want 32 0408 041f", v_cyc.size(), v_dat[8], v_dat[31]); end
    endtask

    task automatic test_boundary;
        int t;
        clear_logs();
        trigger(21'h00040, 8'd0, t);
        tick(4);
        tests_run++;
        if (busy1 !== 1'b0 || ask1 !== 1'b0 || (a_cyc.size() + r_cyc.size() + p_cyc.size()) !== 0) begin
            tests_failed++; $display("FAIL len0 busy=%b ask=%b cmds=%0d want 0 0 0", busy1, ask1, a_cyc.size() + r_cyc.size() + p_cyc.size()); end
        trigger(21'h1FFFFF, 8'd2, t);
        wait_idle(100, "top_addr");
        tests_run++;
        if (a_cyc.size() !== 2 || a_row[0] !== 12'hFFF || a_row[1] !== 12'h000) begin
            tests_failed++; $display("FAIL top_act n=%0d rows %h %h want fff 000", a_cyc.size(), a_row[0], a_row[1]); end
        tests_run++;
        if (r_cyc.size() !== 2 || r_col[0] !== 12'h1FC || r_col[1] !== 12'h000) begin
            tests_failed++; $display("FAIL top_cols n=%0d got %h %h want 1fc 000", r_cyc.size(), r_col[0], r_col[1]); end
        tests_run++;
        if (v_cyc.size() !== 8 || v_dat[0] !== 16'hFFFC || v_dat[3] !== 16'hFFFF || v_dat[4] !== 16'h0000) begin
            tests_failed++; $display("FAIL top_data n=%0d got %h %h %h want fffc ffff 0000", v_cyc.size(), v_dat[0], v_dat[3], v_dat[4]); end
    endtask

    task automatic test_reset_mid;
        int t, k = 0, seen = 0;
        clear_logs();
        trigger(21'h00000, 8'd2, t);
        while (!vld1 && k < 40) begin @(negedge sclk); k++; end
        tests_run++;
        if (vld1 !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_vld_wait got %b want 1", vld1); end
        srst_n = 1'b0;
        @(negedge sclk);
        tests_run++;
        if ({cmd1, addr1, data1, vld1, busy1, ask1, end1} !== {4'b0111, 32'h0}) begin
            tests_failed++; $display("FAIL rst_mid_outputs cmd=%b addr=%h data=%h vld=%b busy=%b want 0111 0 0 0 0", cmd1, addr1, data1, vld1, busy1); end
        srst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin @(negedge sclk); if (vld1 || vld2 || cmd1 != 4'b0111) seen++; end
        tests_run++;
        if (seen !== 0) begin tests_failed++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", seen); end
    endtask

    task automatic test_ignored_trig;
        int t, k = 0;
        clear_logs();
        trigger(21'h00800, 8'd3, t);
        while (cmd1 != 4'b0101 && k < 30) begin @(negedge sclk); k++; end
        rd_addr = 21'h12345; rd_len = 8'd9; rd_trig = 1'b1;
        @(negedge sclk);
        rd_trig = 1'b0;
        wait_idle(100, "ignored_trig");
        tests_run++;
        if (r_cyc.size() !== 3 || a_cyc.size() !== 1 || a_row[0] !== 12'h004 || r_col[2] !== 12'h008 || v_cyc.size() !== 12) begin
            tests_failed++; $display("FAIL ign_trig reads=%0d acts=%0d row=%h col2=%h vld=%0d want 3 1 004 008 12", r_cyc.size(), a_cyc.size(), a_row[0], r_col[2], v_cyc.size()); end
        tests_run++;
        if (r2_cyc.size() !== 3 || v2_cyc.size() !== 12 || v2_cyc[0] !== r2_cyc[0] + 3 || v2_cyc[3] !== r2_cyc[0] + 6) begin
            tests_failed++; $display("FAIL cas2_timing reads=%0d vld=%0d first=%0d want 3 12 %0d", r2_cyc.size(), v2_cyc.size(), v2_cyc[0], r2_cyc[0] + 3); end
        tests_run++;
        if (v2_dat[0] !== 16'h0800 || v2_dat[11] !== 16'h080B) begin
            tests_failed++; $display("FAIL cas2_data got %h %h want 0800 080b", v2_dat[0], v2_dat[11]); end
        tests_run++;
        if (overlap !== 0) begin tests_failed++; $display("FAIL ask_end_overlap got %0d want 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_row_cross();
        test_yield();
        test_boundary();
        test_reset_mid();
        test_ignored_trig();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
